// File: rtl/fir_ctrl_seq.sv
// -----------------------------------------------------------------------------
// fir_ctrl_seq
// Control sequencer for a 10-tap FIR filter running off the 12 MHz clock.
//   - Free-running /20 divider producing the 600 kHz sample strobe.
//   - Sample register that captures the raw sample on every strobe.
//   - Coefficient reload: a request is followed by a flag cycle, ten
//     handshaked RAM writes (tap 0..9) and two tail cycles.
//   - Per-sample coefficient read burst (10 reads plus 2 drain cycles) with
//     delayed multiplier / accumulator enables.
//
// Ports
//   iClk12M          in   12 MHz clock, rising edge
//   iRsn             in   asynchronous active-low reset
//   iCoeffWrReq      in   single-cycle coefficient reload request
//   iCoeffValid      in   coefficient word valid
//   iCoeffData[15:0] in   coefficient word, tap order 0..9
//   oCoeffReady      out  sequencer accepts iCoeffData this cycle
//   iFirIn[2:0]      in   raw filter sample
//   oFirIn[2:0]      out  registered sample for the filter
//   oEnSample600k    out  one-cycle sample strobe every 20 clocks
//   oCoeffUpdateFlag out  coefficient update in progress
//   oCsnRam, oWrnRam out  coefficient RAM chip select / write, active low
//   oAddrRam[5:0]    out  coefficient RAM address
//   oWtDtRam[15:0]   out  coefficient RAM write data
//   oEnMul           out  multiplier enable
//   oEnAddAcc        out  adder / accumulator enable
//   oBusy            out  sequencer not idle
//   oCoeffDone       out  pulse after a completed coefficient reload
//   oSampleMiss      out  pulse when a strobe is dropped
// -----------------------------------------------------------------------------
module fir_ctrl_seq (
  input  logic        iClk12M,
  input  logic        iRsn,
  input  logic        iCoeffWrReq,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeffData,
  output logic        oCoeffReady,
  input  logic [2:0]  iFirIn,
  output logic [2:0]  oFirIn,
  output logic        oEnSample600k,
  output logic        oCoeffUpdateFlag,
  output logic        oCsnRam,
  output logic        oWrnRam,
  output logic [5:0]  oAddrRam,
  output logic [15:0] oWtDtRam,
  output logic        oEnMul,
  output logic        oEnAddAcc,
  output logic        oBusy,
  output logic        oCoeffDone,
  output logic        oSampleMiss
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UPD_FLAG = 3'd1,
    UPD_WR   = 3'd2,
    UPD_TAIL = 3'd3,
    RD       = 3'd4,
    DRAIN    = 3'd5
  } state_t;

  state_t      state_r;
  state_t      nextState_s;
  logic [4:0]  divCnt_r;
  logic        enSample_r;
  logic [2:0]  firIn_r;
  logic        pending_r;
  logic [3:0]  idx_r;
  logic        enMul_r;
  logic        enAddAcc_r;
  logic        coeffDone_r;

  logic        pendEff_s;
  logic        inUpd_s;
  logic        idxLast_s;
  logic        twoDone_s;

  // A request in the same cycle as a strobe must already win the IDLE decision.
  assign pendEff_s = pending_r | iCoeffWrReq;
  assign inUpd_s   = (state_r == UPD_FLAG) || (state_r == UPD_WR) || (state_r == UPD_TAIL);
  assign idxLast_s = (idx_r == 4'd9);
  // Tail and drain phases both last two cycles, counted on the shared index.
  assign twoDone_s = (idx_r == 4'd1);

  // Free-running sample divider and registered strobe.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      divCnt_r   <= 5'd0;
      enSample_r <= 1'b0;
    end else begin
      divCnt_r   <= (divCnt_r == 5'd19) ? 5'd0 : divCnt_r + 5'd1;
      enSample_r <= (divCnt_r == 5'd19);
    end
  end

  // Sample register loads on every strobe, even when the read burst is dropped.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      firIn_r <= 3'd0;
    end else if (enSample_r) begin
      firIn_r <= iFirIn;
    end else begin
      firIn_r <= firIn_r;
    end
  end

  // Pending reload request; requests during an update merge into it.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      pending_r <= 1'b0;
    end else if ((state_r == IDLE) && pendEff_s) begin
      pending_r <= 1'b0;
    end else if (iCoeffWrReq && !inUpd_s) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // FSM state register.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (pendEff_s) begin
          nextState_s = UPD_FLAG;
        end else if (enSample_r) begin
          nextState_s = RD;
        end else begin
          nextState_s = IDLE;
        end
      end
      UPD_FLAG: nextState_s = UPD_WR;
      UPD_WR: begin
        if (iCoeffValid && idxLast_s) begin
          nextState_s = UPD_TAIL;
        end else begin
          nextState_s = UPD_WR;
        end
      end
      UPD_TAIL: nextState_s = twoDone_s ? IDLE : UPD_TAIL;
      RD:       nextState_s = idxLast_s ? DRAIN : RD;
      DRAIN:    nextState_s = twoDone_s ? IDLE : DRAIN;
      default:  nextState_s = IDLE;
    endcase
  end

  // Shared word / cycle index; cleared on every state change so it never passes 9.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      idx_r <= 4'd0;
    end else if (nextState_s != state_r) begin
      idx_r <= 4'd0;
    end else begin
      case (state_r)
        UPD_WR:                idx_r <= iCoeffValid ? idx_r + 4'd1 : idx_r;
        UPD_TAIL, RD, DRAIN:   idx_r <= idx_r + 4'd1;
        default:               idx_r <= 4'd0;
      endcase
    end
  end

  // Delayed datapath enables and the reload completion pulse.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      enMul_r     <= 1'b0;
      enAddAcc_r  <= 1'b0;
      coeffDone_r <= 1'b0;
    end else begin
      enMul_r     <= (state_r == RD);
      enAddAcc_r  <= enMul_r;
      coeffDone_r <= (state_r == UPD_TAIL) && twoDone_s;
    end
  end

  // FSM output decode; write data passes straight through on an accepted word.
  always_comb begin
    oCoeffUpdateFlag = 1'b0;
    oCoeffReady      = 1'b0;
    oCsnRam          = 1'b1;
    oWrnRam          = 1'b1;
    oAddrRam         = 6'd0;
    oWtDtRam         = 16'd0;
    case (state_r)
      UPD_FLAG: oCoeffUpdateFlag = 1'b1;
      UPD_WR: begin
        oCoeffUpdateFlag = 1'b1;
        oCoeffReady      = 1'b1;
        if (iCoeffValid) begin
          oCsnRam  = 1'b0;
          oWrnRam  = 1'b0;
          oAddrRam = {2'b00, idx_r};
          oWtDtRam = iCoeffData;
        end else begin
          oCsnRam  = 1'b1;
          oWrnRam  = 1'b1;
        end
      end
      UPD_TAIL: oCoeffUpdateFlag = 1'b1;
      RD: begin
        oCsnRam  = 1'b0;
        oAddrRam = {2'b00, idx_r};
      end
      default: oCoeffUpdateFlag = 1'b0;
    endcase
  end

  // A strobe is only usable in IDLE with no reload waiting; otherwise it is dropped.
  assign oSampleMiss   = enSample_r && !((state_r == IDLE) && !pendEff_s);
  assign oBusy         = (state_r != IDLE);
  assign oEnSample600k = enSample_r;
  assign oFirIn        = firIn_r;
  assign oEnMul        = enMul_r;
  assign oEnAddAcc     = enAddAcc_r;
  assign oCoeffDone    = coeffDone_r;

endmodule

// File: doc/fir_ctrl_seq.md
FIR_CTRL_SEQ -- requirements
Module: fir_ctrl_seq

Interface
REQ-001 SHALL have port iClk12M  input  1  12 MHz system clock, all logic on rising edge.
REQ-002 SHALL have port iRsn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port iCoeffWrReq  input  1  single-cycle request to reload the 10-tap coefficient set.
REQ-004 SHALL have ports iCoeffValid  input  1 and iCoeffData  input  16: coefficient word stream, tap order 0..9.
REQ-005 SHALL have port oCoeffReady  output  1  sequencer accepts iCoeffData this cycle.
REQ-006 SHALL have port iFirIn  input  3  raw filter sample.
REQ-007 SHALL have port oFirIn  output  3  sample register feeding filter iFirIn.
REQ-008 SHALL have port oEnSample600k  output  1  one-cycle sample strobe, period 20 clocks.
REQ-009 SHALL have ports oCoeffUpdateFlag 1, oCsnRam 1, oWrnRam 1, oAddrRam 6, oWtDtRam 16, oEnMul 1, oEnAddAcc 1 (all outputs), driving the matching filter inputs.
REQ-010 SHALL have ports oBusy  output  1 (FSM not IDLE), oCoeffDone  output  1 (pulse), oSampleMiss  output  1 (pulse).

Function
REQ-011 Divider counts 0..19, wraps to 0; oEnSample600k SHALL be high exactly the cycle after count==19 (registered).
REQ-012 oFirIn SHALL load iFirIn on each cycle oEnSample600k is high; holds otherwise.
REQ-013 iCoeffWrReq SHALL set a pending bit, cleared on entry to UPD_FLAG; repeated requests while pending/busy merge into one.
REQ-014 FSM states: IDLE, UPD_FLAG, UPD_WR, UPD_TAIL, RD, DRAIN.
REQ-015 IDLE->UPD_FLAG when pending set; else IDLE->RD the cycle after an oEnSample600k strobe; pending has priority when both apply in the same cycle.
REQ-016 UPD_FLAG: 1 cycle, oCoeffUpdateFlag=1, oCsnRam=oWrnRam=1; then UPD_WR.
REQ-017 UPD_WR: oCoeffUpdateFlag=1, oCoeffReady=1; on iCoeffValid&oCoeffReady SHALL drive oCsnRam=0, oWrnRam=0, oAddrRam=word index, oWtDtRam=iCoeffData same cycle (combinational pass); index increments.
REQ-018 UPD_WR with iCoeffValid=0: oCsnRam=oWrnRam=1, index holds (stall, unbounded).
REQ-019 After 10th accepted word, oCoeffReady=0, ->UPD_TAIL; UPD_TAIL holds oCoeffUpdateFlag=1, Csn/Wrn=1, oAddrRam=0, oWtDtRam=0 for 2 cycles; on exit oCoeffDone pulses 1 cycle, ->IDLE.
REQ-020 RD: 10 cycles k=0..9, oCsnRam=0, oWrnRam=1, oAddrRam=k; then DRAIN 2 cycles with oCsnRam=1, oAddrRam=0; then IDLE.
REQ-021 With RD entry cycle R: oEnMul SHALL be high cycles R+1..R+10, oEnAddAcc high cycles R+2..R+11 (registered delays of the read enable).
REQ-022 oEnSample600k strobe arriving while FSM not IDLE/eligible (update in progress) SHALL be dropped and pulse oSampleMiss same cycle; oFirIn still loads.
REQ-023 oAddrRam[5:4] SHALL always be 0; index counter 4 bits, never exceeds 9.
REQ-024 Coefficient words presented outside UPD_WR SHALL be ignored (oCoeffReady=0).
REQ-025 Read burst (12 cycles) SHALL complete before next strobe; divider free-runs independent of FSM.

Reset
REQ-026 iRsn low SHALL immediately force: FSM IDLE, divider 0, pending 0, index 0, oFirIn 0, oEnSample600k 0, oCoeffUpdateFlag 0, oCsnRam 1, oWrnRam 1, oAddrRam 0, oWtDtRam 0, oEnMul 0, oEnAddAcc 0, oCoeffReady 0, oBusy 0, oCoeffDone 0, oSampleMiss 0.
REQ-027 Reset mid-UPD_WR or mid-RD SHALL abandon the operation; no resume, no oCoeffDone.
REQ-028 First strobe after reset release SHALL occur on the 21st rising edge.

Verification
REQ-029 Reset release, idle 60 cycles -> oEnSample600k pulses every 20 cycles, first at edge 21; RAM lines idle (Csn=Wrn=1).
REQ-030 iCoeffWrReq, stream 0x0A00..0x0A09 with valid constant -> flag 1 cycle early, 10 writes addr 0..9 with matching data, 2 tail cycles, oCoeffDone once.
REQ-031 Same stream with valid dropped for 3 cycles after word 4 -> Csn=1 during gap, addr resumes at 5, total 10 writes.
REQ-032 iFirIn=3'b001 at a strobe -> oFirIn=001; reads addr 0..9 at R..R+9, oEnMul R+1..R+10, oEnAddAcc R+2..R+11.
REQ-033 iCoeffWrReq pulsed same cycle as strobe and again during UPD_WR -> update wins, one update only, strobe during update raises oSampleMiss.
REQ-034 iRsn asserted at write index 6 -> all outputs to REQ-026 values immediately; later request restarts at addr 0.
